// File: rtl/psum_bias_server.sv
// psum_bias_server
// Bias source and output sink for a single PU. Pass 0 serves init_bias.
// Later channel passes serve the partial sums captured in the previous pass.
// After the last pass the NUM_OUT results are drained downstream, with an
// optional ReLU applied on the way out.
`timescale 1ns/1ps

module psum_bias_server #(
    parameter int N_PIXELS = 5,
    parameter int CH_WIDTH = 8,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CH_WIDTH-1:0] num_channels,
    input  logic signed [31:0]  init_bias,
    input  logic                bias_pop_req,
    output logic signed [31:0]  biasValue,
    output logic                biasValid,
    input  logic signed [31:0]  pu_out,
    input  logic                pu_outvalid,
    output logic                pu_clear,
    output logic signed [31:0]  res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                done,
    output logic                proto_err
);

    localparam int N_OUT   = N_PIXELS - 2;
    localparam int NUM_OUT = N_OUT * N_OUT;
    localparam int PTR_W   = $clog2(NUM_OUT + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_OUT - 1);
    localparam logic [PTR_W-1:0] FULL_IDX = PTR_W'(NUM_OUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [PTR_W-1:0]    rd_ptr;    // pop index in ACCUM, drain index in DRAIN
    logic [PTR_W-1:0]    wr_ptr;
    logic [CH_WIDTH-1:0] ch_cnt;    // completed passes
    logic [CH_WIDTH-1:0] channels;
    logic signed [31:0]  init_q;
    logic signed [31:0]  psum_buf [NUM_OUT];

    logic pop_ok, pop_bad, cap_ok, cap_bad, pass_end, more_passes;
    logic drain_acc, drain_last;

    assign pop_ok      = (state == S_ACCUM) && bias_pop_req && (rd_ptr != FULL_IDX);
    assign pop_bad     = bias_pop_req && !pop_ok;
    assign cap_ok      = (state == S_ACCUM) && pu_outvalid;
    assign cap_bad     = pu_outvalid && (state != S_ACCUM);
    assign pass_end    = cap_ok && (wr_ptr == LAST_IDX);
    assign more_passes = ({1'b0, ch_cnt} + (CH_WIDTH+1)'(1)) < {1'b0, channels};
    assign drain_acc   = (state == S_DRAIN) && res_ready;
    assign drain_last  = drain_acc && (rd_ptr == LAST_IDX);

    assign pu_clear  = (state == S_CLR);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_DRAIN);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for every clocked register so all flops update together at the edge.
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (otherwise a latch is inferred).
        state_d = state;
        unique case (state)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_ACCUM;
            S_ACCUM: if (pass_end) state_d = more_passes ? S_CLR : S_DRAIN;
            S_DRAIN: if (drain_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job registers, pointers, bias serving and the sticky protocol flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            ch_cnt    <= '0;
            channels  <= '0;
            init_q    <= '0;
            biasValue <= '0;
            biasValid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            biasValid <= 1'b0;

            if ((state == S_IDLE) && start) begin
                channels  <= (num_channels == '0) ? CH_WIDTH'(1) : num_channels;
                init_q    <= init_bias;
                ch_cnt    <= '0;
                proto_err <= 1'b0;
            end

            if (state == S_CLR) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end

            // A same-cycle capture to the same index lands after this read,
            // so the served value is always the previous pass's entry.
            if (pop_ok) begin
                biasValid <= 1'b1;
                biasValue <= (ch_cnt == '0) ? init_q : psum_buf[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
            end

            if (cap_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (pass_end) begin
                    if (more_passes) ch_cnt <= ch_cnt + CH_WIDTH'(1);
                    else             rd_ptr <= '0;  // rd_ptr becomes the drain index
                end
            end

            if (drain_acc) rd_ptr <= rd_ptr + PTR_W'(1);

            if (pop_bad || cap_bad) proto_err <= 1'b1;
        end
    end

    // Partial-sum buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: storage array is not reset; every entry is written in pass 0 before it is ever read.
        if (cap_ok) psum_buf[wr_ptr] <= pu_out;
    end

    // Drain output with optional ReLU; forced to zero outside DRAIN.
    always_comb begin
        res_data = '0;
        if (state == S_DRAIN) begin
            if (RELU_EN && psum_buf[rd_ptr][31]) res_data = '0;
            else                                 res_data = psum_buf[rd_ptr];
        end
    end

endmodule
